// File: rtl/rf_wb_sched.sv
// Writeback scheduler: round-robin arbiter between ALU (A) and load (B) writeback
// sources, a registered register-file write port, and a busy-register scoreboard.
// Optional feature: define RF_WB_BYPASS_EN to add writeback-to-read forwarding outputs.
module rf_wb_sched #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr0,
  input  logic [4:0]  raddr1,
  output logic        hazard0,
  output logic        hazard1,
  output logic [31:0] busy_mask
`ifdef RF_WB_BYPASS_EN
  ,
  output logic        fwd0_en,
  output logic        fwd1_en,
  output logic [31:0] fwd0_data,
  output logic [31:0] fwd1_data
`endif
);

  logic        last_b_q, last_b_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_vec, clr_vec;
  logic        grant_a, grant_b;

  // Handshake: a source transfers at a rising edge where its valid and ready are
  // both 1. Ready depends on valid and never on a registered handshake, so a source
  // may hold valid until it sees ready; ready is only ever given to one source.
  always_comb begin
    a_ready = rst_n & a_valid & (~b_valid | last_b_q);
    b_ready = rst_n & b_valid & (~a_valid | ~last_b_q);
  end

  assign grant_a = a_valid & a_ready;
  assign grant_b = b_valid & b_ready;

  always_comb begin
    last_b_d   = last_b_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_a) begin
      last_b_d = 1'b0;
      if (a_addr != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = a_addr;
        rf_wdata_d = a_data;
      end
    end else if (grant_b) begin
      last_b_d = 1'b1;
      if (b_addr != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = b_addr;
        rf_wdata_d = b_data;
      end
    end
  end

  // Reservation set is OR'd in after the clear so a re-reserve wins over retirement.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_valid && (rsv_addr != 5'd0)) set_vec[rsv_addr] = 1'b1;
    if (rf_we_q) clr_vec[rf_waddr_q] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b_q   <= RR_INIT;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      last_b_q   <= last_b_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_mask = busy_q;

`ifdef RF_WB_BYPASS_EN
  logic rsv_hit0, rsv_hit1;

  // A register being written this cycle can be forwarded instead of stalling,
  // unless it is reserved again by a younger instruction at the same edge.
  always_comb begin
    fwd0_en   = rf_we_q && (rf_waddr_q == raddr0) && (raddr0 != 5'd0);
    fwd1_en   = rf_we_q && (rf_waddr_q == raddr1) && (raddr1 != 5'd0);
    fwd0_data = rf_wdata_q;
    fwd1_data = rf_wdata_q;
    rsv_hit0  = rsv_valid && (rsv_addr == raddr0);
    rsv_hit1  = rsv_valid && (rsv_addr == raddr1);
    hazard0   = busy_q[raddr0] & ~(fwd0_en & ~rsv_hit0);
    hazard1   = busy_q[raddr1] & ~(fwd1_en & ~rsv_hit1);
  end
`else
  assign hazard0 = busy_q[raddr0];
  assign hazard1 = busy_q[raddr1];
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: reference model plus write scoreboard,
// directed scenarios followed by a random phase. Honours RF_WB_BYPASS_EN.
module tb_rf_wb_sched;

  localparam logic RR_INIT = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr0, raddr1;
  logic        hazard0, hazard1;
  logic [31:0] busy_mask;
`ifdef RF_WB_BYPASS_EN
  logic        fwd0_en, fwd1_en;
  logic [31:0] fwd0_data, fwd1_data;
`endif

  rf_wb_sched #(.RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr0(raddr0), .raddr1(raddr1), .hazard0(hazard0), .hazard1(hazard1),
    .busy_mask(busy_mask)
`ifdef RF_WB_BYPASS_EN
    , .fwd0_en(fwd0_en), .fwd1_en(fwd1_en), .fwd0_data(fwd0_data), .fwd1_data(fwd1_data)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model state
  logic [36:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_ok = 1'b0;
  logic        m_last_b = RR_INIT;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_busy = '0;
  logic        obs_ra, obs_rb;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    rsv_valid = 1'b0; rsv_addr = '0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    logic        ra, rb, h0, h1, hit0, hit1;
    logic [31:0] clr, set, nb;
    logic [36:0] e;
    #1;
    ra = rst_n & a_valid & (~b_valid | m_last_b);
    rb = rst_n & b_valid & (~a_valid | ~m_last_b);
    obs_ra = a_ready;
    obs_rb = b_ready;
    check("a_ready", {63'd0, a_ready}, {63'd0, ra});
    check("b_ready", {63'd0, b_ready}, {63'd0, rb});
    if (m_ok) begin
      h0 = m_busy[raddr0];
      h1 = m_busy[raddr1];
      hit0 = m_we && (m_waddr == raddr0) && (raddr0 != 5'd0);
      hit1 = m_we && (m_waddr == raddr1) && (raddr1 != 5'd0);
`ifdef RF_WB_BYPASS_EN
      if (hit0 && !(rsv_valid && rsv_addr == raddr0)) h0 = 1'b0;
      if (hit1 && !(rsv_valid && rsv_addr == raddr1)) h1 = 1'b0;
      check("fwd0_en", {63'd0, fwd0_en}, {63'd0, hit0});
      check("fwd1_en", {63'd0, fwd1_en}, {63'd0, hit1});
      if (hit0) check("fwd0_data", {32'd0, fwd0_data}, {32'd0, m_wdata});
      if (hit1) check("fwd1_data", {32'd0, fwd1_data}, {32'd0, m_wdata});
`endif
      check("hazard0", {63'd0, hazard0}, {63'd0, h0});
      check("hazard1", {63'd0, hazard1}, {63'd0, h1});
    end
    if (!rst_n) begin
      m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_last_b = RR_INIT; m_ok = 1'b1;
      exp_q.delete();
    end else begin
      clr = '0; set = '0;
      if (m_we && m_waddr != 5'd0) clr[m_waddr] = 1'b1;
      if (rsv_valid && rsv_addr != 5'd0) set[rsv_addr] = 1'b1;
      nb = (m_busy & ~clr) | set;
      nb[0] = 1'b0;
      m_we = 1'b0;
      if (ra) begin
        m_last_b = 1'b0;
        if (a_addr != 5'd0) begin
          m_we = 1'b1; m_waddr = a_addr; m_wdata = a_data;
          exp_q.push_back({a_addr, a_data});
        end
      end else if (rb) begin
        m_last_b = 1'b1;
        if (b_addr != 5'd0) begin
          m_we = 1'b1; m_waddr = b_addr; m_wdata = b_data;
          exp_q.push_back({b_addr, b_data});
        end
      end
      m_busy = nb;
    end
    @(posedge clk);
    @(negedge clk);
    check("rf_we", {63'd0, rf_we}, {63'd0, m_we});
    if (rf_we === 1'b1) begin
      check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
      end
    end
    check("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
    check("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
    check("busy_mask", {32'd0, busy_mask}, {32'd0, m_busy});
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic reserve(input logic [4:0] r);
    idle();
    rsv_valid = 1'b1; rsv_addr = r;
    tick();
  endtask

  task automatic write_a(input logic [4:0] ad, input logic [31:0] d);
    idle();
    a_valid = 1'b1; a_addr = ad; a_data = d;
    tick();
  endtask

  logic [3:0] rr_pat;

  initial begin
    idle();
    raddr0 = '0; raddr1 = '0;
    rst_n = 1'b0;
    @(negedge clk);

    // reset state
    do_reset();
    check("rst_busy", {32'd0, busy_mask}, 64'd0);
    check("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);

    // reserve x5, write it back from A
    reserve(5'd5);
    check("s1_busy5_set", {63'd0, busy_mask[5]}, 64'd1);
    write_a(5'd5, 32'hDEADBEEF);
    check("s1_a_ready", {63'd0, obs_ra}, 64'd1);
    check("s1_rf_we", {63'd0, rf_we}, 64'd1);
    check("s1_rf_waddr", {59'd0, rf_waddr}, 64'd5);
    check("s1_rf_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
    idle();
    tick();
    check("s1_busy5_clr", {63'd0, busy_mask[5]}, 64'd0);
    check("s1_hold_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);

    // contention: A, B, A, B
    do_reset();
    rr_pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      idle();
      a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA000_0000 + i;
      b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB000_0000 + i;
      tick();
      check("rr_grant_a", {63'd0, obs_ra}, {63'd0, rr_pat[i]});
      check("rr_grant_b", {63'd0, obs_rb}, {63'd0, ~rr_pat[i]});
      check("rr_rf_we", {63'd0, rf_we}, 64'd1);
    end

    // set wins over clear on the same register
    do_reset();
    reserve(5'd7);
    write_a(5'd7, 32'h0000_0777);
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd7; raddr0 = 5'd7;
    tick();
    check("s3_busy7", {63'd0, busy_mask[7]}, 64'd1);
    check("s3_hazard0", {63'd0, hazard0}, 64'd1);
    raddr0 = '0;

    // write to x0 completes the handshake but never writes
    do_reset();
    idle();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
    tick();
    check("s4_b_ready", {63'd0, obs_rb}, 64'd1);
    check("s4_rf_we", {63'd0, rf_we}, 64'd0);
    check("s4_busy", {32'd0, busy_mask}, 64'd0);

    // reset drops a pending grant and restores the round-robin pointer
    for (int r = 4; r < 8; r++) reserve(5'(r));
    check("s5_busy_f0", {32'd0, busy_mask}, 64'h0000_00F0);
    write_a(5'd3, 32'h3);
    idle();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h12;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h13;
    rst_n = 1'b0;
    tick();
    check("s5_ready_in_rst", {62'd0, obs_ra, obs_rb}, 64'd0);
    check("s5_busy", {32'd0, busy_mask}, 64'd0);
    check("s5_rf_we", {63'd0, rf_we}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("s5_a_wins", {62'd0, obs_ra, obs_rb}, 64'd2);

    // bypass of a register retiring in the current cycle
    do_reset();
    reserve(5'd9);
    write_a(5'd9, 32'hCAFE0001);
    idle();
    raddr1 = 5'd9;
    #1;
`ifdef RF_WB_BYPASS_EN
    check("s6_fwd1_en", {63'd0, fwd1_en}, 64'd1);
    check("s6_fwd1_data", {32'd0, fwd1_data}, 64'hCAFE0001);
    check("s6_hazard1", {63'd0, hazard1}, 64'd0);
`else
    check("s6_hazard1", {63'd0, hazard1}, 64'd1);
`endif
    tick();
    raddr1 = '0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      rsv_valid = $urandom_range(0, 1);
      rsv_addr  = 5'($urandom_range(0, 15));
      a_valid   = $urandom_range(0, 1);
      a_addr    = 5'($urandom_range(0, 15));
      a_data    = $urandom;
      b_valid   = $urandom_range(0, 1);
      b_addr    = 5'($urandom_range(0, 15));
      b_data    = $urandom;
      raddr0    = 5'($urandom_range(0, 15));
      raddr1    = 5'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    check("sb_drain", {32'd0, exp_q.size()}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 SHALL have parameter: RR_INIT, 1'b1, reset value of last-grant flag (1 = B granted last, so A wins first contention).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: rsv_valid  input  1 / rsv_addr  input  5  reserve destination register at issue.
REQ-005 SHALL have ports: a_valid  input  1 / a_addr  input  5 / a_data  input  32 / a_ready  output  1  writeback source A (ALU).
REQ-006 SHALL have ports: b_valid  input  1 / b_addr  input  5 / b_data  input  32 / b_ready  output  1  writeback source B (load).
REQ-007 SHALL have ports: rf_we  output  1 / rf_waddr  output  5 / rf_wdata  output  32  registered register-file write port.
REQ-008 SHALL have ports: raddr0, raddr1  input  5 each / hazard0, hazard1  output  1 each  read-operand hazard flags.
REQ-009 SHALL have port: busy_mask  output  32  pending-write bitmap, bit n = xn.

Function
REQ-010 SHALL grant at most one source per cycle; handshake = valid & ready at a rising edge.
REQ-011 SHALL make a_ready/b_ready combinational: only one valid -> that one ready; both valid -> the source not granted last is ready.
REQ-012 SHALL update the last-grant flag only on a completed handshake; idle cycles leave it unchanged.
REQ-013 SHALL register the granted addr/data into rf_waddr/rf_wdata and drive rf_we = 1 in the cycle after the handshake (latency 1).
REQ-014 SHALL drive rf_we = 0 when no handshake occurred or the granted address is 0; the handshake still completes for address 0.
REQ-015 SHALL hold rf_waddr/rf_wdata unchanged when rf_we is 0.
REQ-016 SHALL set busy_mask[rsv_addr] at the edge where rsv_valid = 1 and rsv_addr != 0.
REQ-017 SHALL clear busy_mask[rf_waddr] at the edge where rf_we = 1, i.e. the edge at which the register file stores the data.
REQ-018 SHALL let set win over clear when both target the same register at the same edge.
REQ-019 SHALL keep busy_mask[0] = 0 always.
REQ-020 SHALL drive hazardN = busy_mask[raddrN] combinationally; raddrN = 0 gives 0.
REQ-021 SHALL accept writebacks to non-busy registers without error; the write proceeds and the mask is unaffected.

Reset
REQ-022 SHALL, while rst_n = 0 at an edge, clear busy_mask, rf_we, rf_waddr and rf_wdata to 0 and load last-grant from RR_INIT.
REQ-023 SHALL drop a handshake at the reset edge; no rf_we follows it, and a_ready/b_ready are 0 while rst_n = 0.

Configuration
REQ-024 SHALL compile, with RF_WB_BYPASS_EN defined, extra outputs fwd0_en, fwd1_en (1 bit) and fwd0_data, fwd1_data (32 bit).
REQ-025 SHALL, with RF_WB_BYPASS_EN, assert fwdN_en and drive fwdN_data = rf_wdata when rf_we = 1, rf_waddr = raddrN and raddrN != 0.
REQ-026 SHALL, with RF_WB_BYPASS_EN, suppress hazardN in that same case unless raddrN is re-reserved at that edge.
REQ-027 SHALL, without RF_WB_BYPASS_EN, omit the fwd ports, and hazardN follows REQ-020 only.

Verification
REQ-028 SHALL test this scenario: reset, rsv x5, then a_valid with addr 5 and data 0xDEADBEEF -> a_ready = 1; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; busy_mask[5] = 0 after that edge.
REQ-029 SHALL test this scenario: a_valid and b_valid held 4 cycles after reset -> grants A, B, A, B; rf_we = 1 each following cycle.
REQ-030 SHALL test this scenario: rsv x7 and rf_we for x7 at the same edge -> busy_mask[7] stays 1 and hazard0 = 1 with raddr0 = 7.
REQ-031 SHALL test this scenario: b_valid with addr 0 and data 0x1234 -> b_ready = 1, rf_we stays 0, and busy_mask stays 0x00000000.
REQ-032 SHALL test this scenario: rst_n = 0 for one edge with busy_mask 0x000000F0 and a pending grant -> busy_mask = 0, rf_we = 0 next cycle, and A wins next contention.
REQ-033 SHALL test this scenario: with RF_WB_BYPASS_EN, raddr1 = 9 during a cycle with rf_we for x9 and data 0xCAFE0001 -> fwd1_en = 1, fwd1_data = 0xCAFE0001, hazard1 = 0.
